// File: rtl/nn_adder_pkg.sv
// nn_adder_pkg: sizing and arithmetic helpers shared by the adder tree and its stages
package nn_adder_pkg;
  localparam int MAX_WIDTH = 64;
  typedef logic signed [MAX_WIDTH-1:0] wide_sum_t;
  function automatic int tree_levels(input int n);
    int l = 0;
    for (int m = n; m > 1; m = (m + 1) / 2) l++;
    return l;
  endfunction
  // Element count after lvl rounds of pairwise reduction; an odd element carries through.
  function automatic int level_count(input int n, input int lvl);
    int m = n;
    for (int i = 0; i < lvl; i++) m = (m + 1) / 2;
    return m;
  endfunction
  function automatic wide_sum_t sat_clamp(input wide_sum_t value, input int width);
    wide_sum_t hi = (wide_sum_t'(1) <<< (width - 1)) - 1;
    wide_sum_t lo = -hi - 1;
    return value > hi ? hi : value < lo ? lo : value;
  endfunction
endpackage

// File: rtl/adder_tree_stage.sv
// adder_tree_stage: one registered tree level; PAIR=1 adds adjacent pairs, PAIR=0 only registers.
module adder_tree_stage #(
  parameter int N_IN = 2,
  parameter int WIDTH = 16,
  parameter bit PAIR = 1'b1,
  localparam int N_OUT = PAIR ? (N_IN + 1) / 2 : N_IN
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [N_IN*WIDTH-1:0]  data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [N_OUT*WIDTH-1:0] data_out,
  output logic                   valid_out,
  input  logic                   ready_in
);
  logic [N_OUT*WIDTH-1:0] next_data;
  for (genvar j = 0; j < N_OUT; j++) begin : g_elem
    if (!PAIR) begin : g_pass
      assign next_data[j*WIDTH +: WIDTH] = data_in[j*WIDTH +: WIDTH];
    end else if (2 * j + 1 < N_IN) begin : g_add
      assign next_data[j*WIDTH +: WIDTH] = $signed(data_in[2*j*WIDTH +: WIDTH])
                                         + $signed(data_in[(2*j+1)*WIDTH +: WIDTH]);
    end else begin : g_odd
      assign next_data[j*WIDTH +: WIDTH] = data_in[2*j*WIDTH +: WIDTH];
    end
  end
  // An empty stage loads regardless of downstream, which is what collapses bubbles.
  assign ready_out = !valid_out || ready_in;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      data_out <= '0;
    end else if (ready_out) begin
      valid_out <= valid_in;
      if (valid_in) data_out <= next_data;
    end
  end
endmodule

// File: rtl/adder_tree.sv
// adder_tree: pipelined signed reduction of NUM_ADDENDS addends with valid/ready flow control.
// Define ADDER_TREE_SAT_EN to clamp a narrowed sum (and flag sat_out) instead of wrapping it.
module adder_tree
  import nn_adder_pkg::*;
#(
  parameter int NUM_ADDENDS = 8,
  parameter int ADDEND_WIDTH = 16,
  parameter int LEVELS = tree_levels(NUM_ADDENDS),
  parameter int FULL_WIDTH = ADDEND_WIDTH + LEVELS,
  parameter int SUM_WIDTH = FULL_WIDTH
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [NUM_ADDENDS*ADDEND_WIDTH-1:0] addends_in,
  input  logic                                valid_in,
  output logic                                ready_out,
  output logic [SUM_WIDTH-1:0]                sum_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic                                sat_out
);
  logic [NUM_ADDENDS*FULL_WIDTH-1:0] ext;
  logic [LEVELS+1:0] vld, rdy;
  logic [FULL_WIDTH-1:0] fin;
  for (genvar i = 0; i < NUM_ADDENDS; i++) begin : g_ext
    assign ext[i*FULL_WIDTH +: FULL_WIDTH] = FULL_WIDTH'($signed(addends_in[i*ADDEND_WIDTH +: ADDEND_WIDTH]));
  end
  assign vld[0] = valid_in;
  assign rdy[LEVELS+1] = ready_in;
  // Level 0 only registers the widened addends; levels 1..LEVELS reduce pairwise.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int NI = k == 0 ? NUM_ADDENDS : level_count(NUM_ADDENDS, k - 1);
    logic [NI*FULL_WIDTH-1:0] din;
    logic [level_count(NUM_ADDENDS, k)*FULL_WIDTH-1:0] dout;
    if (k == 0) begin : g_src
      assign din = ext;
    end else begin : g_src
      assign din = g_lvl[k-1].dout;
    end
    adder_tree_stage #(.N_IN(NI), .WIDTH(FULL_WIDTH), .PAIR(k != 0)) u_stage (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .data_in(din),
      .valid_in(vld[k]),
      .ready_out(rdy[k]),
      .data_out(dout),
      .valid_out(vld[k+1]),
      .ready_in(rdy[k+1])
    );
  end
  assign fin = g_lvl[LEVELS].dout;
  assign ready_out = rdy[0];
  assign valid_out = vld[LEVELS+1];
`ifdef ADDER_TREE_SAT_EN
  wide_sum_t full, clamped;
  assign full = wide_sum_t'($signed(fin));
  assign clamped = sat_clamp(full, SUM_WIDTH);
  assign sum_out = SUM_WIDTH'(clamped);
  assign sat_out = valid_out && clamped != full;
`else
  assign sum_out = SUM_WIDTH'(fin);
  assign sat_out = 1'b0;
`endif
endmodule

// File: tb/tb_adder_tree.sv
// tb_adder_tree: four tree configurations driven in lockstep against a per-config reference scoreboard.
module tb_adder_tree;
  localparam int NADD[4] = '{8, 5, 1, 4};
  localparam int CAP[4] = '{4, 4, 1, 3};
  typedef struct { longint sum; bit sat; int cyc; } item_t;
  logic clk_in, rst_n_in, valid_in, ready_in;
  logic [127:0] a0;
  logic [79:0] a1;
  logic [15:0] a2;
  logic [63:0] a3;
  logic [18:0] s0, s1;
  logic [15:0] s2, s3;
  logic [3:0] ready_o, valid_o, sat_o;
  int av[4][8];
  item_t sb[4][$];
  bit held[4];
  longint held_sum[4];
  bit lat_chk;
  int cyc, nvec, miss;

  adder_tree #(.NUM_ADDENDS(8), .ADDEND_WIDTH(16)) u0 (.clk_in(clk_in), .rst_n_in(rst_n_in), .addends_in(a0),
    .valid_in(valid_in), .ready_out(ready_o[0]), .sum_out(s0), .valid_out(valid_o[0]), .ready_in(ready_in), .sat_out(sat_o[0]));
  adder_tree #(.NUM_ADDENDS(5), .ADDEND_WIDTH(16)) u1 (.clk_in(clk_in), .rst_n_in(rst_n_in), .addends_in(a1),
    .valid_in(valid_in), .ready_out(ready_o[1]), .sum_out(s1), .valid_out(valid_o[1]), .ready_in(ready_in), .sat_out(sat_o[1]));
  adder_tree #(.NUM_ADDENDS(1), .ADDEND_WIDTH(16)) u2 (.clk_in(clk_in), .rst_n_in(rst_n_in), .addends_in(a2),
    .valid_in(valid_in), .ready_out(ready_o[2]), .sum_out(s2), .valid_out(valid_o[2]), .ready_in(ready_in), .sat_out(sat_o[2]));
  adder_tree #(.NUM_ADDENDS(4), .ADDEND_WIDTH(16), .SUM_WIDTH(16)) u3 (.clk_in(clk_in), .rst_n_in(rst_n_in), .addends_in(a3),
    .valid_in(valid_in), .ready_out(ready_o[3]), .sum_out(s3), .valid_out(valid_o[3]), .ready_in(ready_in), .sat_out(sat_o[3]));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input longint obs, input longint exp);
    nvec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 8; i++) a0[i*16 +: 16] = 16'(av[0][i]);
    for (int i = 0; i < 5; i++) a1[i*16 +: 16] = 16'(av[1][i]);
    a2 = 16'(av[2][0]);
    for (int i = 0; i < 4; i++) a3[i*16 +: 16] = 16'(av[3][i]);
  endtask

  task automatic randomize_all();
    for (int d = 0; d < 4; d++) for (int i = 0; i < 8; i++) av[d][i] = int'($signed(16'($urandom)));
    apply();
  endtask

  // Reference: exact integer sum; the 16-bit config wraps or clamps to the signed 16-bit range.
  task automatic model(input int d, output longint e, output bit sat);
    longint s = 0;
    for (int i = 0; i < NADD[d]; i++) s += av[d][i];
    e = s;
    sat = 1'b0;
    if (d == 3) begin
`ifdef ADDER_TREE_SAT_EN
      if (s > 32767) begin e = 32767; sat = 1'b1; end
      else if (s < -32768) begin e = -32768; sat = 1'b1; end
`else
      e = ((s % 65536) + 65536) % 65536;
      if (e > 32767) e -= 65536;
`endif
    end
  endtask

  task automatic tick();
    longint act[4];
    item_t it;
    @(negedge clk_in);
    act[0] = longint'($signed(s0));
    act[1] = longint'($signed(s1));
    act[2] = longint'($signed(s2));
    act[3] = longint'($signed(s3));
    for (int d = 0; d < 4; d++) begin
      if (held[d]) begin
        chk($sformatf("hold_valid%0d", d), valid_o[d], 1);
        chk($sformatf("hold_sum%0d", d), act[d], held_sum[d]);
      end
      held[d] = valid_o[d] && !ready_in;
      held_sum[d] = act[d];
      chk($sformatf("ready_out%0d", d), ready_o[d], longint'(ready_in || sb[d].size() < CAP[d]));
      if (valid_o[d] && ready_in) begin
        if (sb[d].size() == 0) chk($sformatf("spurious_valid%0d", d), valid_o[d], 0);
        else begin
          it = sb[d].pop_front();
          chk($sformatf("sum%0d", d), act[d], it.sum);
          chk($sformatf("sat%0d", d), sat_o[d], it.sat);
          if (lat_chk) chk($sformatf("latency%0d", d), cyc - it.cyc, CAP[d]);
        end
      end
      if (valid_in && ready_o[d]) begin
        model(d, it.sum, it.sat);
        it.cyc = cyc;
        sb[d].push_back(it);
      end
    end
    cyc++;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1; lat_chk = 1'b0;
    cyc = 0; nvec = 0; miss = 0;
    for (int d = 0; d < 4; d++) for (int i = 0; i < 8; i++) av[d][i] = 0;
    apply();
    @(negedge clk_in);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_valid%0d", d), valid_o[d], 0);
      chk($sformatf("rst_ready%0d", d), ready_o[d], 1);
      chk($sformatf("rst_sat%0d", d), sat_o[d], 0);
    end
    chk("rst_sum0", s0, 0);
    chk("rst_sum3", s3, 0);
    @(posedge clk_in); #1 rst_n_in = 1'b1;
    // Directed: 1..8, five -32768, a single -7, four 20000 (overflows 16 bits).
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) av[0][i] = i + 1;
    for (int i = 0; i < 5; i++) av[1][i] = -32768;
    av[2][0] = -7;
    for (int i = 0; i < 4; i++) av[3][i] = 20000;
    apply();
    valid_in = 1'b1; tick(); valid_in = 1'b0;
    repeat (6) tick();
    // Full throughput with latency checked on every result.
    for (int t = 0; t < 20; t++) begin randomize_all(); valid_in = 1'b1; tick(); end
    valid_in = 1'b0;
    repeat (6) tick();
    lat_chk = 1'b0;
    // Back-to-back stream with the output stalled over cycles 3..10.
    for (int t = 0; t < 24; t++) begin
      randomize_all();
      valid_in = t < 16;
      ready_in = !(t >= 3 && t <= 10);
      tick();
    end
    valid_in = 1'b0; ready_in = 1'b1;
    repeat (6) tick();
    for (int t = 0; t < 400; t++) begin
      randomize_all();
      valid_in = $urandom_range(0, 3) != 0;
      ready_in = $urandom_range(0, 3) != 0;
      tick();
    end
    valid_in = 1'b0; ready_in = 1'b1;
    repeat (8) tick();
    for (int d = 0; d < 4; d++) chk($sformatf("drain%0d", d), sb[d].size(), 0);
    // Reset with three items in flight: outputs clear at once, then one fresh item passes alone.
    for (int t = 0; t < 3; t++) begin randomize_all(); valid_in = 1'b1; tick(); end
    valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("midrst_valid%0d", d), valid_o[d], 0);
      chk($sformatf("midrst_sat%0d", d), sat_o[d], 0);
      sb[d].delete();
      held[d] = 1'b0;
    end
    chk("midrst_sum0", s0, 0);
    chk("midrst_sum1", s1, 0);
    @(posedge clk_in); #1 rst_n_in = 1'b1;
    lat_chk = 1'b1;
    randomize_all();
    valid_in = 1'b1; tick(); valid_in = 1'b0;
    repeat (6) tick();
    for (int d = 0; d < 4; d++) chk($sformatf("post_rst_drain%0d", d), sb[d].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
    $finish;
  end
endmodule
